// File: rtl/ifu_fetch.sv
// Instruction fetch unit: holds the architectural PC, issues one read per instruction
// on a valid/ready memory channel and hands the returned word to decode.
module ifu_fetch #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_arvalid,
    output logic [ADDR_W-1:0] mem_araddr,
    input  logic              mem_arready,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    input  logic [1:0]        mem_rresp,
    output logic              mem_rready,
    output logic              inst_valid,
    output logic [31:0]       inst,
    output logic [ADDR_W-1:0] pc,
    input  logic              inst_ready,
    input  logic [ADDR_W-1:0] next_pc,
    output logic              fetch_err,
    output logic [31:0]       fetch_cnt
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t            state_r, state_s;
    logic              arvalid_r, arvalid_s;
    logic              rready_r, rready_s;
    logic              inst_valid_r, inst_valid_s;
    logic [31:0]       inst_r, inst_s;
    logic [ADDR_W-1:0] pc_r, pc_s;
    logic              err_r, err_s;
    logic [31:0]       cnt_r, cnt_s;

    // Next-state and next-output logic; every output is a register loaded from here.
    always_comb begin
        state_s      = state_r;
        arvalid_s    = arvalid_r;
        rready_s     = rready_r;
        inst_valid_s = inst_valid_r;
        inst_s       = inst_r;
        pc_s         = pc_r;
        err_s        = err_r;
        cnt_s        = cnt_r;
        case (state_r)
            S_REQ: begin
                if (arvalid_r && mem_arready) begin
                    arvalid_s = 1'b0;
                    rready_s  = 1'b1;
                    state_s   = S_WAIT;
                end else begin
                    arvalid_s = 1'b1;
                end
            end
            S_WAIT: begin
                if (rready_r && mem_rvalid) begin
                    rready_s = 1'b0;
                    if (mem_rresp == 2'b00) begin
                        inst_s       = mem_rdata;
                        inst_valid_s = 1'b1;
                        state_s      = S_HOLD;
                    end else begin
                        err_s   = 1'b1;
                        state_s = S_ERR;
                    end
                end else begin
                    rready_s = 1'b1;
                end
            end
            S_HOLD: begin
                if (inst_valid_r && inst_ready) begin
                    pc_s         = next_pc;
                    cnt_s        = cnt_r + 32'd1;
                    inst_valid_s = 1'b0;
                    // Raising arvalid on the retire edge gives 3-cycle back-to-back fetch.
                    if (next_pc[1:0] == 2'b00) begin
                        arvalid_s = 1'b1;
                        state_s   = S_REQ;
                    end else begin
                        err_s   = 1'b1;
                        state_s = S_ERR;
                    end
                end else begin
                    inst_valid_s = inst_valid_r;
                end
            end
            S_ERR: begin
                arvalid_s    = 1'b0;
                rready_s     = 1'b0;
                inst_valid_s = 1'b0;
                err_s        = 1'b1;
            end
            default: begin
                arvalid_s    = 1'b0;
                rready_s     = 1'b0;
                inst_valid_s = 1'b0;
                err_s        = 1'b1;
                state_s      = S_ERR;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= S_REQ;
            arvalid_r    <= 1'b0;
            rready_r     <= 1'b0;
            inst_valid_r <= 1'b0;
            inst_r       <= 32'h0000_0000;
            pc_r         <= RESET_PC;
            err_r        <= 1'b0;
            cnt_r        <= 32'h0000_0000;
        end else begin
            state_r      <= state_s;
            arvalid_r    <= arvalid_s;
            rready_r     <= rready_s;
            inst_valid_r <= inst_valid_s;
            inst_r       <= inst_s;
            pc_r         <= pc_s;
            err_r        <= err_s;
            cnt_r        <= cnt_s;
        end
    end

    assign mem_arvalid = arvalid_r;
    assign mem_araddr  = pc_r;
    assign mem_rready  = rready_r;
    assign inst_valid  = inst_valid_r;
    assign inst        = inst_r;
    assign pc          = pc_r;
    assign fetch_err   = err_r;
    assign fetch_cnt   = cnt_r;

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: cycle table, throughput sequence and a
// randomized run against a transaction-level memory/PC model.
module tb_ifu_fetch;

    localparam logic [31:0] RPC = 32'h8000_0000;

    logic        clk, rst;
    logic        mem_arvalid, mem_arready, mem_rvalid, mem_rready;
    logic        inst_valid, inst_ready, fetch_err;
    logic [31:0] mem_araddr, mem_rdata, inst, pc, next_pc, fetch_cnt;
    logic [1:0]  mem_rresp;
    int          total, bad;

    ifu_fetch #(.ADDR_W(32), .RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst),
        .mem_arvalid(mem_arvalid), .mem_araddr(mem_araddr), .mem_arready(mem_arready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rresp(mem_rresp),
        .mem_rready(mem_rready), .inst_valid(inst_valid), .inst(inst), .pc(pc),
        .inst_ready(inst_ready), .next_pc(next_pc), .fetch_err(fetch_err),
        .fetch_cnt(fetch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst, ard, rv;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic        irdy;
        logic [31:0] npc;
        logic        e_arv, e_rr, e_iv;
        logic [31:0] e_inst, e_pc;
        logic        e_err;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t tbl[32];

    function automatic vec_t mk(input logic r, input logic ard, input logic rv,
                                input logic [31:0] rd, input logic [1:0] rr,
                                input logic irdy, input logic [31:0] npc,
                                input logic arv, input logic rrdy, input logic iv,
                                input logic [31:0] ins, input logic [31:0] p,
                                input logic err, input logic [31:0] cnt);
        vec_t v;
        v.rst = r; v.ard = ard; v.rv = rv; v.rdata = rd; v.rresp = rr;
        v.irdy = irdy; v.npc = npc; v.e_arv = arv; v.e_rr = rrdy; v.e_iv = iv;
        v.e_inst = ins; v.e_pc = p; v.e_err = err; v.e_cnt = cnt;
        return v;
    endfunction

    // Memory contents: instruction word derived from its address.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hA5C3_0F96;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        mem_rresp = 2'b00; inst_ready = 1'b0; next_pc = 32'h0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        step();
        rst = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        clear_inputs();

        // ---------------- table-driven cycle script ----------------
        //            rst ard rv rdata          rresp  irdy npc            arv rr iv inst           pc             err cnt
        tbl[0]  = mk(1, 0, 0, 32'h0,          2'b00, 0, 32'h0,          0, 0, 0, 32'h0,          RPC,           0, 32'd0);
        tbl[1]  = mk(0, 1, 0, 32'h0,          2'b00, 0, 32'h0,          1, 0, 0, 32'h0,          RPC,           0, 32'd0);
        tbl[2]  = mk(0, 1, 0, 32'h0,          2'b00, 0, 32'h0,          0, 1, 0, 32'h0,          RPC,           0, 32'd0);
        tbl[3]  = mk(0, 0, 1, 32'h0000_0413,  2'b00, 0, 32'h0,          0, 0, 1, 32'h0000_0413,  RPC,           0, 32'd0);
        tbl[4]  = mk(0, 0, 0, 32'h0,          2'b00, 0, 32'h0,          0, 0, 1, 32'h0000_0413,  RPC,           0, 32'd0);
        tbl[5]  = mk(0, 0, 1, 32'hFFFF_FFFF,  2'b00, 0, 32'h8000_0040,  0, 0, 1, 32'h0000_0413,  RPC,           0, 32'd0);
        tbl[6]  = mk(0, 1, 0, 32'h0,          2'b00, 0, 32'h8000_0001,  0, 0, 1, 32'h0000_0413,  RPC,           0, 32'd0);
        tbl[7]  = mk(0, 0, 0, 32'h0,          2'b00, 0, 32'h0,          0, 0, 1, 32'h0000_0413,  RPC,           0, 32'd0);
        tbl[8]  = mk(0, 0, 0, 32'h0,          2'b00, 0, 32'h0,          0, 0, 1, 32'h0000_0413,  RPC,           0, 32'd0);
        tbl[9]  = mk(0, 0, 0, 32'h0,          2'b00, 1, 32'h8000_0004,  1, 0, 0, 32'h0000_0413,  32'h8000_0004, 0, 32'd1);
        tbl[10] = mk(0, 0, 0, 32'h0,          2'b00, 0, 32'h0,          1, 0, 0, 32'h0000_0413,  32'h8000_0004, 0, 32'd1);
        tbl[11] = mk(0, 0, 0, 32'h0,          2'b00, 0, 32'h0,          1, 0, 0, 32'h0000_0413,  32'h8000_0004, 0, 32'd1);
        tbl[12] = mk(0, 0, 0, 32'h0,          2'b00, 0, 32'h0,          1, 0, 0, 32'h0000_0413,  32'h8000_0004, 0, 32'd1);
        tbl[13] = mk(0, 0, 0, 32'h0,          2'b00, 0, 32'h0,          1, 0, 0, 32'h0000_0413,  32'h8000_0004, 0, 32'd1);
        tbl[14] = mk(0, 1, 0, 32'h0,          2'b00, 0, 32'h0,          0, 1, 0, 32'h0000_0413,  32'h8000_0004, 0, 32'd1);
        tbl[15] = mk(0, 0, 1, 32'h0010_0093,  2'b00, 0, 32'h0,          0, 0, 1, 32'h0010_0093,  32'h8000_0004, 0, 32'd1);
        tbl[16] = mk(0, 0, 0, 32'h0,          2'b00, 1, 32'h8000_0102,  0, 0, 0, 32'h0010_0093,  32'h8000_0102, 1, 32'd2);
        tbl[17] = mk(0, 1, 1, 32'h0000_1234,  2'b00, 0, 32'h0,          0, 0, 0, 32'h0010_0093,  32'h8000_0102, 1, 32'd2);
        tbl[18] = mk(0, 1, 0, 32'h0,          2'b00, 1, 32'h8000_0200,  0, 0, 0, 32'h0010_0093,  32'h8000_0102, 1, 32'd2);
        tbl[19] = mk(1, 0, 0, 32'h0,          2'b00, 0, 32'h0,          0, 0, 0, 32'h0,          RPC,           0, 32'd0);
        tbl[20] = mk(0, 0, 0, 32'h0,          2'b00, 0, 32'h0,          1, 0, 0, 32'h0,          RPC,           0, 32'd0);
        tbl[21] = mk(0, 1, 0, 32'h0,          2'b00, 0, 32'h0,          0, 1, 0, 32'h0,          RPC,           0, 32'd0);
        tbl[22] = mk(0, 0, 1, 32'h0000_0BAD,  2'b10, 0, 32'h0,          0, 0, 0, 32'h0,          RPC,           1, 32'd0);
        tbl[23] = mk(0, 1, 0, 32'h0,          2'b00, 1, 32'h8000_0008,  0, 0, 0, 32'h0,          RPC,           1, 32'd0);
        tbl[24] = mk(1, 0, 0, 32'h0,          2'b00, 0, 32'h0,          0, 0, 0, 32'h0,          RPC,           0, 32'd0);
        tbl[25] = mk(0, 0, 0, 32'h0,          2'b00, 0, 32'h0,          1, 0, 0, 32'h0,          RPC,           0, 32'd0);
        tbl[26] = mk(0, 1, 0, 32'h0,          2'b00, 0, 32'h0,          0, 1, 0, 32'h0,          RPC,           0, 32'd0);
        tbl[27] = mk(1, 0, 0, 32'h0,          2'b00, 0, 32'h0,          0, 0, 0, 32'h0,          RPC,           0, 32'd0);
        tbl[28] = mk(0, 0, 1, 32'hDEAD_BEEF,  2'b00, 0, 32'h0,          1, 0, 0, 32'h0,          RPC,           0, 32'd0);
        tbl[29] = mk(0, 0, 0, 32'h0,          2'b00, 0, 32'h0,          1, 0, 0, 32'h0,          RPC,           0, 32'd0);
        tbl[30] = mk(0, 1, 0, 32'h0,          2'b00, 0, 32'h0,          0, 1, 0, 32'h0,          RPC,           0, 32'd0);
        tbl[31] = mk(0, 0, 1, 32'h0000_0013,  2'b00, 0, 32'h0,          0, 0, 1, 32'h0000_0013,  RPC,           0, 32'd0);

        for (int i = 0; i < 32; i++) begin
            rst = tbl[i].rst; mem_arready = tbl[i].ard; mem_rvalid = tbl[i].rv;
            mem_rdata = tbl[i].rdata; mem_rresp = tbl[i].rresp;
            inst_ready = tbl[i].irdy; next_pc = tbl[i].npc;
            step();
            check($sformatf("row%0d_arvalid", i), {31'd0, mem_arvalid}, {31'd0, tbl[i].e_arv});
            check($sformatf("row%0d_araddr", i), mem_araddr, tbl[i].e_pc);
            check($sformatf("row%0d_rready", i), {31'd0, mem_rready}, {31'd0, tbl[i].e_rr});
            check($sformatf("row%0d_inst_valid", i), {31'd0, inst_valid}, {31'd0, tbl[i].e_iv});
            check($sformatf("row%0d_inst", i), inst, tbl[i].e_inst);
            check($sformatf("row%0d_pc", i), pc, tbl[i].e_pc);
            check($sformatf("row%0d_fetch_err", i), {31'd0, fetch_err}, {31'd0, tbl[i].e_err});
            check($sformatf("row%0d_fetch_cnt", i), fetch_cnt, tbl[i].e_cnt);
        end

        // ---------------- zero-wait memory: latency and throughput ----------------
        begin
            int first_arv, first_iv, last_ret, n_ret;
            first_arv = -1; first_iv = -1; last_ret = -1; n_ret = 0;
            do_reset();
            for (int c = 0; c < 40; c++) begin
                if (mem_arvalid && first_arv < 0) first_arv = c;
                mem_arready = mem_arvalid;
                mem_rvalid  = mem_rready;
                mem_rdata   = memf(mem_araddr);
                mem_rresp   = 2'b00;
                inst_ready  = 1'b1;
                next_pc     = pc + 32'd4;
                if (inst_valid) begin
                    if (first_iv < 0) first_iv = c;
                    if (last_ret >= 0) check("retire_interval", c - last_ret, 32'd3);
                    check("tp_inst", inst, memf(pc));
                    check("tp_pc", pc, RPC + 32'd4 * n_ret);
                    last_ret = c;
                    n_ret++;
                end
                step();
            end
            check("first_latency", first_iv - first_arv, 32'd2);
            check("tp_fetch_cnt", fetch_cnt, n_ret);
        end

        // ---------------- randomized run against transaction model ----------------
        begin
            logic [31:0] exp_pc, exp_cnt, resp_addr, prev_addr;
            logic        prev_stall, ar_hs, r_hs, ret;
            int          resp_wait, retires;
            exp_pc = RPC; exp_cnt = 32'd0; resp_addr = 32'd0; prev_addr = 32'd0;
            prev_stall = 1'b0; resp_wait = -1; retires = 0;
            do_reset();
            for (int c = 0; c < 1500; c++) begin
                if (prev_stall) begin
                    check("rnd_arvalid_held", {31'd0, mem_arvalid}, 32'd1);
                    check("rnd_araddr_held", mem_araddr, prev_addr);
                end
                if (resp_wait > 0) resp_wait--;
                clear_inputs();
                if (resp_wait == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = memf(resp_addr);
                end else if (resp_wait < 0 && $urandom_range(0, 7) == 0) begin
                    // stray response outside an outstanding read
                    mem_rvalid = 1'b1;
                    mem_rdata  = $urandom;
                    mem_rresp  = 2'($urandom_range(0, 3));
                end else begin
                    mem_arready = ($urandom_range(0, 1) == 1);
                end
                inst_ready = ($urandom_range(0, 1) == 1);
                ret   = inst_valid && inst_ready;
                ar_hs = mem_arvalid && mem_arready;
                r_hs  = mem_rready && mem_rvalid;
                if (ret) begin
                    if ($urandom_range(0, 1) == 1) next_pc = exp_pc + 32'd4;
                    else next_pc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
                end else begin
                    next_pc = $urandom;
                end
                if (ar_hs) begin
                    check("rnd_req_addr", mem_araddr, exp_pc);
                    resp_addr = mem_araddr;
                    resp_wait = $urandom_range(1, 3);
                end
                if (r_hs) resp_wait = -1;
                if (ret) begin
                    check("rnd_inst", inst, memf(exp_pc));
                    check("rnd_pc", pc, exp_pc);
                    check("rnd_cnt", fetch_cnt, exp_cnt);
                    exp_pc  = next_pc;
                    exp_cnt = exp_cnt + 32'd1;
                    retires++;
                end
                prev_stall = mem_arvalid && !mem_arready;
                prev_addr  = mem_araddr;
                step();
            end
            check("rnd_enough_retires", {31'd0, retires >= 50}, 32'd1);
            check("rnd_final_cnt", fetch_cnt, exp_cnt);
            check("rnd_no_err", {31'd0, fetch_err}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch unit for the RV32E NPC. Sits directly upstream of the decode/control unit.
- Holds the architectural PC and issues one 32-bit read per instruction on a valid/ready memory read channel.
- Presents the returned instruction word with a valid/ready handshake to decode, and loads the next PC supplied by the execute/PC-select stage when decode retires the instruction.
- Converts the datapath from an implicit single-cycle fetch to an explicit multi-cycle fetch.

Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded on reset.
- ADDR_W, 32, PC and memory address width.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- mem_arvalid  output  1  read-address request valid
- mem_araddr  output  ADDR_W  read address, equals pc
- mem_arready  input  1  memory accepts address
- mem_rvalid  input  1  read data valid
- mem_rdata  input  32  read data (instruction word)
- mem_rresp  input  2  response code, 2'b00 = OKAY, anything else = error
- mem_rready  output  1  IFU accepts read data
- inst_valid  output  1  inst/pc hold a fetched instruction
- inst  output  32  instruction word to decode
- pc  output  ADDR_W  address of inst / current fetch address
- inst_ready  input  1  decode/execute retires inst this cycle
- next_pc  input  ADDR_W  PC of the following instruction, sampled on retire
- fetch_err  output  1  sticky fetch fault flag
- fetch_cnt  output  32  number of retired fetches

Behaviour:
- Single clock; reset is synchronous and active-high.
- Reset values:
  - pc = RESET_PC, state = S_REQ.
  - inst = 32'h0, inst_valid = 0, fetch_err = 0, fetch_cnt = 0.
  - mem_arvalid = 0, mem_rready = 0.
- Reset asserted in any state (including mid-request or mid-response) aborts the transaction. Any mem_rvalid arriving after reset deassertion for an aborted request is ignored, because only S_WAIT accepts data.
- All outputs are registered. mem_araddr = pc at all times.
- S_REQ:
  - mem_arvalid = 1 from the first cycle after reset release.
  - mem_arvalid and mem_araddr are held stable until mem_arready.
  - On mem_arvalid && mem_arready: mem_arvalid drops next cycle, mem_rready rises, go to S_WAIT.
- S_WAIT:
  - mem_rready = 1.
  - On mem_rvalid with mem_rresp == 2'b00: latch inst <= mem_rdata, set inst_valid = 1, drop mem_rready, go to S_HOLD.
  - On mem_rvalid with mem_rresp != 2'b00: go to S_ERR.
  - Memory must not assert mem_rvalid in the same cycle as mem_arready. mem_rvalid in S_REQ or S_HOLD is ignored.
- S_HOLD:
  - inst_valid = 1. inst and pc are held stable until retire.
  - Retire = inst_valid && inst_ready. On retire: pc <= next_pc, fetch_cnt <= fetch_cnt + 1 (wraps 32'hFFFF_FFFF -> 0), inst_valid <= 0.
  - If next_pc[1:0] == 2'b00, go to S_REQ. Otherwise go to S_ERR.
  - inst_ready while inst_valid = 0 has no effect.
- S_ERR:
  - fetch_err = 1. mem_arvalid = 0, mem_rready = 0, inst_valid = 0.
  - pc holds the faulting address (the misaligned next_pc, or the address that returned an error response).
  - Only rst leaves S_ERR.
- Minimum latency, with arready in the request cycle and rvalid in the following cycle: request at cycle N, inst_valid at N+2. Back-to-back throughput is 1 instruction per 3 cycles when inst_ready is held high.
- next_pc is a plain input with no validity of its own. It is meaningful only in the retire cycle.

Test Plan:
- Reset release with memory returning arready immediately, rvalid one cycle later, rdata=32'h0000_0413 -> mem_araddr=32'h8000_0000, inst_valid at cycle 2, inst=32'h0000_0413, pc=32'h8000_0000.
- Memory stalls arready for 4 cycles -> mem_arvalid stays high and mem_araddr is unchanged for all 4 cycles; exactly one address handshake occurs.
- inst_ready held low for 5 cycles, then pulsed with next_pc=32'h8000_0004 -> inst/pc stable throughout; next request address is 32'h8000_0004 and fetch_cnt=1.
- Retire with next_pc=32'h8000_0102 -> S_ERR, fetch_err=1, pc=32'h8000_0102, no further mem_arvalid until rst.
- mem_rresp=2'b10 on a response -> fetch_err=1, inst_valid stays 0; rst for one cycle clears fetch_err and fetch restarts at 32'h8000_0000.
- Reset asserted while in S_WAIT, then a stale rvalid arrives in the first post-reset S_REQ cycle -> rvalid is ignored, inst_valid=0, and a fresh request is issued to RESET_PC.
